// File: rtl/cipher_out_serializer.sv
// Output serializer for the cipher core: buffers 128-bit result blocks in a small FIFO and
// streams each one as four 32-bit words, most significant first, on a ready/valid interface.
module cipher_out_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vin,
    input  logic          tin,
    input  logic [127:0]  din,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_type,
    output logic          m_last,
    output logic [AW:0]   level,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [128:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          xfer, pop, push, drop;
    logic [128:0]  head;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        m_valid = (level_q != '0);
        xfer    = m_valid & m_ready;
        pop     = xfer & (idx_q == 2'd3);
        // A full FIFO still accepts a block when the head leaves in the same cycle.
        push    = vin & ((level_q != FULL) | pop);
        drop    = vin & (level_q == FULL) & ~pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        idx_d    = xfer ? idx_q + 2'd1 : idx_q;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        m_data = '0;
        m_type = 1'b0;
        m_last = 1'b0;
        if (m_valid) begin
            m_type = head[128];
            m_last = (idx_q == 2'd3);
            unique case (idx_q)
                2'd0:    m_data = head[127:96];
                2'd1:    m_data = head[95:64];
                2'd2:    m_data = head[63:32];
                default: m_data = head[31:0];
            endcase
        end
    end

    assign level = level_q;
    assign ovf   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; entries are only read while level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tin, din};
        end
    end

endmodule

// File: doc/cipher_out_serializer.md
# cipher_out_serializer

Downstream stage of the cipher core: captures each 128-bit result block (valid, type, data) the core emits and buffers it in a small FIFO. It then serializes each block into four 32-bit words on a ready/valid master stream toward the host-side output interface. The cipher core has no backpressure, so this block absorbs output bursts and flags any block it has to drop.

## Interface
Parameters:
- DEPTH, 4: FIFO capacity in 128-bit blocks; power of two, at least 2.
- AW, 2: log2(DEPTH).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Reset, asynchronous and active-high.
- vin  in  1  Block valid from the cipher core (its vout).
- tin  in  1  Block type from the core: 0 = encrypt result, 1 = decrypt result.
- din  in  128  Block data from the core (its dout).
- m_valid  out  1  Output word valid.
- m_ready  in  1  Downstream accepts the word.
- m_data  out  32  Output word.
- m_type  out  1  Type of the block being serialized.
- m_last  out  1  High on the 4th word of a block.
- level  out  AW+1  Number of blocks held, counting a partially sent head block.
- ovf  out  1  Sticky overflow flag: a valid block was dropped.
- clr_ovf  in  1  Clears ovf.

## Operation
- Storage: circular FIFO of DEPTH entries, each holding {tin, din}. Write pointer and read pointer are AW bits wide and wrap modulo DEPTH. The occupancy counter `level` runs 0..DEPTH.
- Push condition: a block is pushed when vin=1 and either level<DEPTH, or the head block is popped in the same cycle. In the second case (full FIFO plus same-cycle pop) the write is accepted and level stays at DEPTH.
- Overflow: when vin=1, level=DEPTH and no pop occurs that cycle, the block is discarded and ovf is set.
  - ovf stays set until clr_ovf=1.
  - If clr_ovf and a new drop happen in the same cycle, the set wins and ovf=1.
  - A dropped block never changes any FIFO state.
- Serializer: a word index idx (2 bits) points into the head block.
  - Word order is most significant first: idx 0 → din[127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
- Handshake:
  - m_valid = (level != 0).
  - A transfer occurs on a cycle with m_valid & m_ready.
  - On a transfer with idx<3, idx increments.
  - On a transfer with idx=3, the head block is popped, idx returns to 0 and the read pointer advances.
- Output values:
  - m_last = m_valid & (idx==3).
  - m_type = type of the head block.
  - m_data = 0, m_type = 0 and m_last = 0 whenever m_valid=0.
- Handshake rules:
  - m_valid, m_data, m_type and m_last depend only on registered state. There is no combinational path from m_ready or vin.
  - Once asserted, m_valid stays high and m_data stays stable until the transfer occurs.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Empty FIFO with vin: the block is written, and m_valid rises on the following cycle.

## Timing
- Reset (asynchronous, effective immediately): level=0, pointers=0, idx=0, ovf=0, m_valid=0, m_data=0, m_type=0, m_last=0. FIFO memory is not reset.
- A reset asserted mid-block discards all buffered data. The first block after reset starts at word 0.
- Latency:
  - A block captured at edge N presents word 0 during cycle N+1, provided the FIFO was empty.
  - Sustained throughput is 1 word per cycle, which is 1 block per 4 cycles.
- level updates at the same edge as the push or pop that changes it.
- Burst absorption with m_ready held high: the 4:1 width ratio means a burst of B consecutive core blocks fits without loss if B ≤ DEPTH+floor((B−1)/4).
- ovf sets at the edge that samples the dropped vin. It is visible in the following cycle.

## Test plan
- Single block, m_ready=1:
  - Stimulus: reset, then vin=1, tin=0, din=0x00112233_44556677_8899AABB_CCDDEEFF for 1 cycle.
  - Response: m_valid high for exactly 4 cycles, starting the cycle after capture.
  - m_data sequence: 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - m_last high on the 4th word only; m_type=0; level returns to 0.
- Backpressure:
  - Stimulus: one block with tin=1; m_ready toggles 1,0,0,1,1,0,1.
  - Response: exactly 4 transfers, in MSW-first order.
  - m_data is held stable through every stall; m_type=1 throughout.
- Overflow: m_ready=0, then 5 consecutive blocks with din=1..5.
  - Response: level=4 and ovf=1 after the 5th block; block 5 is lost.
  - With m_ready=1, 16 words drain carrying the word sequences of blocks 1..4.
  - ovf stays 1 until clr_ovf is pulsed, then reads 0.
- Full with same-cycle pop:
  - Stimulus: FIFO full, head at idx=3 with m_ready=1, vin=1 in the same cycle.
  - Response: the block is accepted, level stays 4, ovf stays 0.
  - The new block emerges after the three older blocks.
- Pointer wrap:
  - Stimulus: 10 blocks at a spacing of 1 block per 4 cycles, m_ready=1.
  - Response: all 40 words are in order, level never exceeds 2 and ovf=0.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst between clock edges while word 2 of a block is in flight.
  - Response: m_valid=0, level=0 and ovf=0 immediately, before the next edge.
  - A block sent after reset is released starts at word 0.
